bus_arbiter: RTL and testbench

Two-port Avalon-style bus master that merges the CPU's instruction-fetch and data-access ports onto the single memory bus consumed by `bus_memory`. It arbitrates round-robin between the ports, drives registered bus signals and holds them stable while `waitrequest` is high. It returns read data and a one-cycle done pulse to the winning port, then inserts a turnaround gap so the memory can return to idle.

---
 rtl/bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter merging instruction-fetch and data ports onto one
// Avalon-style memory bus with registered, stall-stable bus outputs.
module bus_arbiter #(
  parameter int WRITE_HOLD = 2,
  parameter int TURNAROUND = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);

  localparam int HW = (WRITE_HOLD < 1) ? 1 : $clog2(WRITE_HOLD + 1);
  localparam int GW = (TURNAROUND < 1) ? 1 : $clog2(TURNAROUND + 1);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(WRITE_HOLD);
  localparam logic [GW-1:0] GAP_LOAD = GW'(TURNAROUND);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GAP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } bus_req_t;

  state_t      r_state, w_next_state;
  bus_req_t    r_bus, w_bus_d;
  logic [HW-1:0] r_hold, w_hold_d, w_hold_inc;
  logic [GW-1:0] r_gap, w_gap_d;
  logic [WW-1:0] r_wait, w_wait_d, w_wait_inc;
  logic        r_last_data, w_last_data_d;
  logic        r_gnt_data, w_gnt_data_d;
  logic [31:0] r_i_rdata, w_i_rdata_d;
  logic [31:0] r_d_rdata, w_d_rdata_d;
  logic        r_i_done, w_i_done_d;
  logic        r_d_done, w_d_done_d;
  logic        r_bus_error, w_bus_error_d;

  logic w_d_req, w_pick_i, w_pick_d, w_complete, w_abort;

  // Instruction wins unless data is also pending and instruction went last.
  assign w_d_req  = d_read | d_write;
  assign w_pick_i = i_req & (~w_d_req | r_last_data);
  assign w_pick_d = w_d_req & ~w_pick_i;

  assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
  assign w_wait_inc = (r_wait == WAIT_MAX) ? r_wait : r_wait + 1'b1;

  assign w_complete = (r_state == S_ACCESS) && !waitrequest &&
                      (!r_bus.wr || (r_hold >= HOLD_MAX));
  assign w_abort    = (r_state == S_ACCESS) && waitrequest &&
                      (w_wait_inc >= WAIT_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_pick_i || w_pick_d) w_next_state = S_ACCESS;
      S_ACCESS: if (w_complete || w_abort) w_next_state = S_GAP;
      S_GAP:    if (r_gap <= GW'(1)) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_bus_d       = r_bus;
    w_hold_d      = r_hold;
    w_gap_d       = r_gap;
    w_wait_d      = r_wait;
    w_last_data_d = r_last_data;
    w_gnt_data_d  = r_gnt_data;
    w_i_rdata_d   = r_i_rdata;
    w_d_rdata_d   = r_d_rdata;
    w_i_done_d    = 1'b0;
    w_d_done_d    = 1'b0;
    w_bus_error_d = r_bus_error;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_i) begin
          w_bus_d      = '{addr: i_addr, wdata: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0};
          w_gnt_data_d = 1'b0;
          w_hold_d     = HW'(1);
          w_wait_d     = '0;
        end else if (w_pick_d) begin
          // A simultaneous read and write is treated as a write.
          w_bus_d      = '{addr: d_addr, wdata: d_wdata, be: d_byteenable,
                           rd: ~d_write, wr: d_write};
          w_gnt_data_d = 1'b1;
          w_hold_d     = HW'(1);
          w_wait_d     = '0;
        end
      end
      S_ACCESS: begin
        w_hold_d = w_hold_inc;
        w_wait_d = waitrequest ? w_wait_inc : '0;
        if (w_complete || w_abort) begin
          w_bus_d.rd    = 1'b0;
          w_bus_d.wr    = 1'b0;
          w_gap_d       = GAP_LOAD;
          w_last_data_d = r_gnt_data;
          w_i_done_d    = ~r_gnt_data;
          w_d_done_d    = r_gnt_data;
        end
        if (w_abort) begin
          w_bus_error_d = 1'b1;
          if (r_gnt_data) w_d_rdata_d = 32'h0;
          else            w_i_rdata_d = 32'h0;
        end else if (w_complete && r_bus.rd) begin
          if (r_gnt_data) w_d_rdata_d = readdata;
          else            w_i_rdata_d = readdata;
        end
      end
      S_GAP: begin
        if (r_gap != '0) w_gap_d = r_gap - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bus       <= '0;
      r_hold      <= '0;
      r_gap       <= '0;
      r_wait      <= '0;
      r_last_data <= 1'b1;
      r_gnt_data  <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus       <= w_bus_d;
      r_hold      <= w_hold_d;
      r_gap       <= w_gap_d;
      r_wait      <= w_wait_d;
      r_last_data <= w_last_data_d;
      r_gnt_data  <= w_gnt_data_d;
      r_i_rdata   <= w_i_rdata_d;
      r_d_rdata   <= w_d_rdata_d;
      r_i_done    <= w_i_done_d;
      r_d_done    <= w_d_done_d;
      r_bus_error <= w_bus_error_d;
    end
  end

  assign address    = r_bus.addr;
  assign writedata  = r_bus.wdata;
  assign byteenable = r_bus.be;
  assign read       = r_bus.rd;
  assign write      = r_bus.wr;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;
  assign i_done     = r_i_done;
  assign d_done     = r_d_done;
  assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a stalling memory slave, a scoreboard of
// expected completions, and a second instance with a short timeout.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_done, d_read, d_write, d_done;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_byteenable, byteenable;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, bus_error;

  logic        t_rst_n, t_i_req, t_wait, t_i_done, t_d_done;
  logic        t_read, t_write, t_bus_error;
  logic [31:0] t_rdin, t_i_rdata, t_d_rdata, t_address, t_writedata;
  logic [3:0]  t_byteenable;

  always #5 clk = ~clk;

  bus_arbiter #(.WRITE_HOLD(2), .TURNAROUND(1), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_done(d_done),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(bus_error));

  bus_arbiter #(.WRITE_HOLD(2), .TURNAROUND(1), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset_n(t_rst_n),
    .i_req(t_i_req), .i_addr(32'hBFC00000), .i_rdata(t_i_rdata), .i_done(t_i_done),
    .d_read(1'b0), .d_write(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_byteenable(4'h0), .d_rdata(t_d_rdata), .d_done(t_d_done),
    .address(t_address), .read(t_read), .write(t_write), .writedata(t_writedata),
    .byteenable(t_byteenable), .waitrequest(t_wait), .readdata(t_rdin),
    .bus_error(t_bus_error));

  // Memory slave: waitrequest high for 'stall' cycles of each transfer.
  logic [31:0] mem [0:255];
  int          stall;
  int          scnt;
  logic        force_wait;

  assign waitrequest = force_wait | ((read | write) && (scnt < stall));
  assign readdata    = mem[address[9:2]];

  always @(posedge clk) begin
    if (!reset_n) begin
      mem[0] <= 32'h3C011234;
      mem[4] <= 32'h0;
      scnt   <= 0;
    end else begin
      scnt <= (read | write) ? ((scnt < stall) ? scnt + 1 : scnt) : 0;
      if (write && !waitrequest)
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  typedef struct { bit port; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Wait for the next done pulse, then pop and compare the scoreboard head.
  task automatic wait_done(input string tag, output int lat, output int wc);
    bit   got = 1'b0;
    exp_t e;
    lat = 0;
    wc  = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (write) wc++;
      got = i_done | d_done;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_port"}, 32'(d_done), 32'(e.port));
      chk({tag, "_overlap"}, 32'(i_done & d_done), 32'd0);
      chk({tag, "_data"}, e.port ? d_rdata : i_rdata, e.data);
    end
  endtask

  int lat, wc, cnt;
  bit got;

  initial begin
    reset_n = 1'b0; i_req = 1'b1; i_addr = 32'hBFC00000;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_byteenable = 4'h0;
    stall = 2; force_wait = 1'b0;
    t_rst_n = 1'b0; t_i_req = 1'b0; t_wait = 1'b0; t_rdin = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({read, write, i_done, d_done, bus_error}), 32'd0);
    chk("rst_addr", address, 32'h0);
    chk("rst_wdata", writedata, 32'h0);
    chk("rst_be", 32'(byteenable), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // Single fetch straight out of reset, two stall cycles.
    reset_n = 1'b1;
    sb.push_back('{1'b0, 32'h3C011234});
    @(negedge clk);
    chk("rel_read", 32'(read), 32'd1);
    chk("rel_addr", address, 32'hBFC00000);
    wait_done("fetch1", lat, wc);
    chk("fetch1_latency", 32'(lat + 1), 32'd4);
    sb.push_back('{1'b0, 32'h3C011234});
    chk("gap_read_done_cycle", 32'(read), 32'd0);
    @(negedge clk);
    chk("gap_read_idle_cycle", 32'(read), 32'd0);
    @(negedge clk);
    chk("regrant_read", 32'(read), 32'd1);
    wait_done("fetch2", lat, wc);
    i_req = 1'b0;

    // Stores: write strobe held for max(WRITE_HOLD, first low waitrequest).
    stall = 0; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'h11111111; d_byteenable = 4'hF;
    sb.push_back('{1'b1, 32'h0});
    wait_done("store1", lat, wc);
    chk("store1_write_cycles", 32'(wc), 32'd2);
    stall = 3; d_wdata = 32'hDEADBEEF;
    sb.push_back('{1'b1, 32'h0});
    wait_done("store2", lat, wc);
    chk("store2_write_cycles", 32'(wc), 32'd4);
    d_write = 1'b0;

    stall = 2; d_read = 1'b1;
    sb.push_back('{1'b1, 32'hDEADBEEF});
    wait_done("load", lat, wc);
    d_read = 1'b0;

    // Tie: last grant was data, so instruction goes first, then alternate.
    stall = 1; i_req = 1'b1; d_read = 1'b1;
    sb.push_back('{1'b0, 32'h3C011234});
    sb.push_back('{1'b1, 32'hDEADBEEF});
    sb.push_back('{1'b0, 32'h3C011234});
    sb.push_back('{1'b1, 32'hDEADBEEF});
    wait_done("tie0", lat, wc);
    wait_done("tie1", lat, wc);
    wait_done("tie2", lat, wc);
    wait_done("tie3", lat, wc);
    i_req = 1'b0; d_read = 1'b0;

    // Bus outputs frozen through a 20-cycle stall.
    repeat (3) @(negedge clk);
    stall = 0; force_wait = 1'b1;
    d_read = 1'b1; d_addr = 32'h10; d_byteenable = 4'h5; d_wdata = 32'h12345678;
    sb.push_back('{1'b1, 32'hDEADBEEF});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold_addr", address, 32'h10);
      chk("hold_wdata", writedata, 32'h12345678);
      chk("hold_ctl", 32'({read, write, byteenable}), 32'h25);
    end
    @(negedge clk);
    force_wait = 1'b0;
    wait_done("hold", lat, wc);
    d_read = 1'b0;
    chk("main_no_error", 32'(bus_error), 32'd0);

    // Timeout instance: a good fetch first so the abort visibly zeroes rdata.
    chk("t_rst_err", 32'(t_bus_error), 32'd0);
    t_wait = 1'b0; t_rdin = 32'hA5A50001; t_i_req = 1'b1; t_rst_n = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = t_i_done;
    end
    chk("t_fetch_done", 32'(got), 32'd1);
    chk("t_fetch_data", t_i_rdata, 32'hA5A50001);
    t_i_req = 1'b0;
    repeat (3) @(negedge clk);
    t_wait = 1'b1; t_i_req = 1'b1;
    got = 1'b0; cnt = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = t_i_done;
      if (t_read) cnt++;
    end
    chk("to_done", 32'(got), 32'd1);
    chk("to_stall_cycles", 32'(cnt), 32'd8);
    chk("to_read_low", 32'(t_read), 32'd0);
    chk("to_err", 32'(t_bus_error), 32'd1);
    chk("to_rdata", t_i_rdata, 32'h0);
    chk("to_no_d_done", 32'(t_d_done), 32'd0);
    t_i_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_err_sticky", 32'(t_bus_error), 32'd1);

    // Reset in the middle of an access: strobe drops, no done.
    t_i_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_read", 32'(t_read), 32'd1);
    t_rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_read", 32'(t_read), 32'd0);
    chk("mid_rst_done", 32'(t_i_done), 32'd0);
    chk("mid_rst_err", 32'(t_bus_error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
